// File: rtl/cc_rd_reg_sm.sv
// Read-register command sequencer: takes a register-number word, reads the register file, echoes the response.
// Defining CC_RD_REG_TIMEOUT_EN adds a bounded wait on tx_tready with the timeout_err flag.
module cc_rd_reg_sm #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_sm,
    output logic        sm_running,
    output logic        sm_done,
    input  logic        rx_tvalid,
    input  logic [31:0] rx_data,
    input  logic [0:3]  rx_tkeep,
    input  logic        rx_tlast,
    output logic        rx_tready,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    input  logic        tx_tready,
    output logic        send_csn,
    output logic        send_cmd,
    output logic        send_inv_cmd,
    output logic        send_reg_num,
    output logic        send_reg_data,
    output logic        reg_num_le,
    output logic        rd_en,
    input  logic        illegal_reg_num,
    input  logic [31:0] reg_rd_data,
    output logic [31:0] rd_data,
    output logic        timeout_err
);

    typedef enum logic [13:0] {
        IDLE          = 14'h0001,
        WAIT_REG_NUM  = 14'h0002,
        LATCH_REG_NUM = 14'h0004,
        ERROR_TLAST   = 14'h0008,
        DRAIN         = 14'h0010,
        CHECK_REG_NUM = 14'h0020,
        ERROR_REG_NUM = 14'h0040,
        READ_REG      = 14'h0080,
        LATCH_DATA    = 14'h0100,
        ECHO_CSN      = 14'h0200,
        ECHO_CC       = 14'h0400,
        ECHO_REG_NUM  = 14'h0800,
        ECHO_DATA     = 14'h1000,
        DONE          = 14'h2000
    } state_t;

    state_t      r_state;
    logic        r_err;
    logic [31:0] r_rd_data;
    logic        w_echo;
    logic        w_timeout_hit;
    logic        w_unused;

    // The word payload is muxed outside this block; only the handshake matters here.
    assign w_unused = ^{rx_data, rx_tkeep};

    assign w_echo = (r_state == ECHO_CSN) || (r_state == ECHO_CC) ||
                    (r_state == ECHO_REG_NUM) || (r_state == ECHO_DATA);

`ifdef CC_RD_REG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;

    assign w_timeout_hit = run_sm && w_echo && !tx_tready &&
                           (r_stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall counter restarts on every accepted word and whenever no response is pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!run_sm || !w_echo || tx_tready) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!run_sm || (r_state == IDLE) || (r_state == DONE)) begin
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else if (!run_sm) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_err   <= 1'b0;
                    r_state <= WAIT_REG_NUM;
                end
                WAIT_REG_NUM: begin
                    if (rx_tvalid) begin
                        r_state <= rx_tlast ? LATCH_REG_NUM : ERROR_TLAST;
                    end
                end
                LATCH_REG_NUM: r_state <= CHECK_REG_NUM;
                ERROR_TLAST: begin
                    r_err   <= 1'b1;
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    if (rx_tvalid && rx_tlast) begin
                        r_state <= ECHO_CSN;
                    end
                end
                CHECK_REG_NUM: r_state <= illegal_reg_num ? ERROR_REG_NUM : READ_REG;
                ERROR_REG_NUM: begin
                    r_err   <= 1'b1;
                    r_state <= ECHO_CSN;
                end
                READ_REG: r_state <= LATCH_DATA;
                LATCH_DATA: begin
                    r_rd_data <= reg_rd_data;
                    r_state   <= ECHO_CSN;
                end
                ECHO_CSN: begin
                    if (w_timeout_hit) r_state <= DONE;
                    else if (tx_tready) r_state <= ECHO_CC;
                end
                ECHO_CC: begin
                    if (w_timeout_hit) r_state <= DONE;
                    else if (tx_tready) r_state <= r_err ? DONE : ECHO_REG_NUM;
                end
                ECHO_REG_NUM: begin
                    if (w_timeout_hit) r_state <= DONE;
                    else if (tx_tready) r_state <= ECHO_DATA;
                end
                ECHO_DATA: begin
                    if (w_timeout_hit) r_state <= DONE;
                    else if (tx_tready) r_state <= DONE;
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from the one-hot state flops; only the drain handshake follows rx_tvalid.
    assign sm_running    = (r_state != IDLE);
    assign sm_done       = (r_state == DONE);
    assign rx_tready     = (r_state == LATCH_REG_NUM) || (r_state == ERROR_TLAST) ||
                           ((r_state == DRAIN) && rx_tvalid);
    assign reg_num_le    = (r_state == LATCH_REG_NUM);
    assign rd_en         = (r_state == READ_REG);
    assign tx_tvalid     = w_echo;
    assign send_csn      = (r_state == ECHO_CSN);
    assign send_cmd      = (r_state == ECHO_CC) && !r_err;
    assign send_inv_cmd  = (r_state == ECHO_CC) && r_err;
    assign send_reg_num  = (r_state == ECHO_REG_NUM);
    assign send_reg_data = (r_state == ECHO_DATA);
    assign tx_tlast      = (r_state == ECHO_DATA) || ((r_state == ECHO_CC) && r_err);
    assign rd_data       = r_rd_data;

endmodule

// File: doc/cc_rd_reg_sm.md
CC_RD_REG_SM -- requirements
Module: cc_rd_reg_sm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the maximum number of cycles spent waiting on tx_tready for one response word.
REQ-002 Port clk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port run_sm, input, 1: dispatcher enable; when low, the state machine is held in IDLE.
REQ-005 Ports sm_running and sm_done, output, 1 each: sm_running is high when not in IDLE; sm_done is high only in DONE.
REQ-006 Ports rx_tvalid (in, 1), rx_data (in, 32), rx_tkeep (in, [0:3]), rx_tlast (in, 1), rx_tready (out, 1): the command stream, positioned after the CSN and CC words.
REQ-007 Ports tx_tvalid (out, 1), tx_tlast (out, 1), tx_tready (in, 1): the response stream; the data path is muxed externally.
REQ-008 Ports send_csn, send_cmd, send_inv_cmd, send_reg_num, send_reg_data, output, 1 each: external TX mux selects.
REQ-009 Ports reg_num_le (out, 1), rd_en (out, 1), illegal_reg_num (in, 1), reg_rd_data (in, 32), rd_data (out, 32): register-file read controls and the latched read value.
REQ-010 Port timeout_err, output, 1: a TX timeout occurred during the current command.

Function
REQ-011 Command packet is CSN, CC, then register number (0x00-0x0f) carried with rx_tlast=1.
REQ-012 Success response is 4 words: CSN, CC, register number, rd_data; tx_tlast is high on the rd_data word.
REQ-013 Error response is 2 words: CSN, then inverse CC; tx_tlast is high on the inverse-CC word.
REQ-014 States are IDLE, WAIT_REG_NUM, LATCH_REG_NUM, ERROR_TLAST, DRAIN, CHECK_REG_NUM, ERROR_REG_NUM, READ_REG, LATCH_DATA, ECHO_CSN, ECHO_CC, ECHO_REG_NUM, ECHO_DATA, DONE, one-hot encoded.
REQ-015 IDLE -> WAIT_REG_NUM unconditionally while run_sm=1.
REQ-016 WAIT_REG_NUM: rx_tvalid&rx_tlast -> LATCH_REG_NUM; rx_tvalid&!rx_tlast -> ERROR_TLAST; otherwise stay.
REQ-017 LATCH_REG_NUM: reg_num_le=1 and rx_tready=1 for one cycle; then -> CHECK_REG_NUM.
REQ-018 ERROR_TLAST: rx_tready=1 for one cycle and error flag set; then -> DRAIN.
REQ-019 DRAIN: rx_tready=rx_tvalid; rx_tvalid&rx_tlast -> ECHO_CSN, with the tlast word consumed.
REQ-020 CHECK_REG_NUM: illegal_reg_num -> ERROR_REG_NUM (error flag set, one cycle, then ECHO_CSN); otherwise -> READ_REG.
REQ-021 READ_REG: rd_en=1 for exactly one cycle; then -> LATCH_DATA.
REQ-022 LATCH_DATA: rd_data <= reg_rd_data (one-cycle register-file latency); then -> ECHO_CSN.
REQ-023 ECHO_* states: tx_tvalid=1 and the matching send_* select is high; a word transfers when tx_tready=1, then the machine advances.
REQ-024 ECHO_* transitions: ECHO_CSN -> ECHO_CC; ECHO_CC -> DONE if error, else -> ECHO_REG_NUM -> ECHO_DATA -> DONE.
REQ-025 ECHO_CC drives send_cmd when no error and send_inv_cmd when error; exactly one select is high per ECHO state.
REQ-026 rx_tready is never high outside LATCH_REG_NUM, ERROR_TLAST and DRAIN.
REQ-027 DONE lasts one cycle, then -> IDLE.
REQ-028 The error flag clears in IDLE and is sticky otherwise.
REQ-029 run_sm low in any state forces IDLE on the next edge; a response in progress is abandoned, and tx_tvalid drops.

Reset
REQ-030 While reset_n is low: state = IDLE; error flag, timeout_err and rd_data = 0; all 1-bit outputs = 0 except sm_running = 0 (IDLE).
REQ-031 On reset_n deassertion, the block waits in IDLE for run_sm.

Configuration
REQ-032 Macro CC_RD_REG_TIMEOUT_EN controls the TX timeout feature.
REQ-033 With CC_RD_REG_TIMEOUT_EN defined: a counter counts cycles in an ECHO state with tx_tready=0, and resets on every transfer.
REQ-034 With CC_RD_REG_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES, the machine goes to DONE and sets timeout_err until IDLE.
REQ-035 Without CC_RD_REG_TIMEOUT_EN: ECHO states wait indefinitely, and timeout_err is tied to 0.

Verification
REQ-036 Reg 0x05 containing 0xDEADBEEF, tx_tready=1 -> rd_en one pulse; words CSN, CC, 0x05, 0xDEADBEEF; tlast on word 4; sm_done one cycle.
REQ-037 Reg num 0x1F with illegal_reg_num=1 -> rd_en never high; 2 words CSN, inverse CC, tlast on word 2.
REQ-038 Reg num with rx_tlast=0, followed by 2 extra words (last with tlast) -> all 3 words consumed; error response of 2 words.
REQ-039 tx_tready held low 10 cycles at ECHO_REG_NUM -> tx_tvalid held, send_reg_num stable; resumes on tready with no word lost or duplicated.
REQ-040 With CC_RD_REG_TIMEOUT_EN and TIMEOUT_CYCLES=8, tx_tready stuck at 0 -> DONE after 8 cycles, timeout_err=1; cleared on the next command.
REQ-041 run_sm dropped mid ECHO_CC, then reset_n pulsed mid WAIT_REG_NUM -> IDLE on the next edge and immediately (asynchronously) respectively; all outputs 0.
